// File: rtl/ocp_arb2.sv
// Two-master to one-slave OCP arbiter: round-robin grant, one transaction in flight.
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
`ifndef ADDR_WIDTH
 `define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
 `define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
 `define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
 `define OCP_CMD_IDLE  3'b000
`endif
`ifndef OCP_CMD_WRITE
 `define OCP_CMD_WRITE 3'b001
`endif
`ifndef OCP_CMD_READ
 `define OCP_CMD_READ  3'b010
`endif

module ocp_arb2 #(
   parameter int TIMEOUT   = 255,
   parameter int CNT_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic [`ADDR_WIDTH-1:0]  i_M0MAddr,
   input  logic [2:0]              i_M0MCmd,
   input  logic [`DATA_WIDTH-1:0]  i_M0MData,
   input  logic [`BEN_WIDTH-1:0]   i_M0MByteEn,
   output logic                    o_M0SCmdAccept,
   output logic [`DATA_WIDTH-1:0]  o_M0SData,
   output logic [1:0]              o_M0SResp,
   input  logic [`ADDR_WIDTH-1:0]  i_M1MAddr,
   input  logic [2:0]              i_M1MCmd,
   input  logic [`DATA_WIDTH-1:0]  i_M1MData,
   input  logic [`BEN_WIDTH-1:0]   i_M1MByteEn,
   output logic                    o_M1SCmdAccept,
   output logic [`DATA_WIDTH-1:0]  o_M1SData,
   output logic [1:0]              o_M1SResp,
   output logic [`ADDR_WIDTH-1:0]  o_MAddr,
   output logic [2:0]              o_MCmd,
   output logic [`DATA_WIDTH-1:0]  o_MData,
   output logic [`BEN_WIDTH-1:0]   o_MByteEn,
   input  logic                    i_SCmdAccept,
   input  logic [`DATA_WIDTH-1:0]  i_SData,
   input  logic [1:0]              i_SResp,
   output logic [1:0]              o_dbg_state
);

   // Handshake: a master holds its command until it samples its SCmdAccept high;
   // a read then completes on the first non-NULL slave response.
   localparam logic [1:0] RESP_NULL = 2'b00;
   localparam logic [1:0] RESP_ERR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t     state;
   logic       owner;
   logic       last;
   logic       req0;
   logic       req1;
   logic [2:0] own_cmd;
   logic       timeout_hit;
   logic [1:0] rsp_fwd;
   logic [`DATA_WIDTH-1:0] dat_fwd;

   assign req0    = (i_M0MCmd != `OCP_CMD_IDLE);
   assign req1    = (i_M1MCmd != `OCP_CMD_IDLE);
   assign own_cmd = owner ? i_M1MCmd : i_M0MCmd;

`ifdef ARB_TIMEOUT_EN
   logic [CNT_WIDTH-1:0] wdog;

   assign timeout_hit = (state == ST_RESP) && (wdog == CNT_WIDTH'(TIMEOUT)) &&
                        (i_SResp == RESP_NULL);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         wdog <= '0;
      else if (state != ST_RESP)
         wdog <= '0;
      else if (wdog != CNT_WIDTH'(TIMEOUT))
         wdog <= wdog + 1'b1;
   end
`else
   // No watchdog in this build; the expression folds to a constant 0.
   assign timeout_hit = (TIMEOUT < 0) || (CNT_WIDTH < 0);
`endif

   assign rsp_fwd = timeout_hit ? RESP_ERR : i_SResp;
   assign dat_fwd = timeout_hit ? '0 : i_SData;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= ST_IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req0 || req1) begin
                  owner <= (req0 && req1) ? ~last : req1;
                  state <= ST_CMD;
               end
            end
            ST_CMD: begin
               // Owner withdrew before accept: drop the grant, pointer untouched.
               if (own_cmd == `OCP_CMD_IDLE) begin
                  state <= ST_IDLE;
               end else if (i_SCmdAccept) begin
                  if (own_cmd == `OCP_CMD_READ) begin
                     state <= ST_RESP;
                  end else begin
                     state <= ST_IDLE;
                     last  <= owner;
                  end
               end
            end
            ST_RESP: begin
               if ((i_SResp != RESP_NULL) || timeout_hit) begin
                  state <= ST_IDLE;
                  last  <= owner;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      o_MCmd         = `OCP_CMD_IDLE;
      o_MAddr        = '0;
      o_MData        = '0;
      o_MByteEn      = '0;
      o_M0SCmdAccept = 1'b0;
      o_M1SCmdAccept = 1'b0;
      o_M0SResp      = RESP_NULL;
      o_M1SResp      = RESP_NULL;
      o_M0SData      = '0;
      o_M1SData      = '0;
      case (state)
         ST_CMD: begin
            o_MCmd    = own_cmd;
            o_MAddr   = owner ? i_M1MAddr   : i_M0MAddr;
            o_MData   = owner ? i_M1MData   : i_M0MData;
            o_MByteEn = owner ? i_M1MByteEn : i_M0MByteEn;
            if (owner) o_M1SCmdAccept = i_SCmdAccept;
            else       o_M0SCmdAccept = i_SCmdAccept;
         end
         ST_RESP: begin
            if (owner) begin
               o_M1SResp = rsp_fwd;
               o_M1SData = dat_fwd;
            end else begin
               o_M0SResp = rsp_fwd;
               o_M0SData = dat_fwd;
            end
         end
         default: ;
      endcase
   end

   assign o_dbg_state = state;

endmodule

// File: tb/tb_ocp_arb2.sv
// Randomised bench for ocp_arb2: bench masters and slave, a transaction-level
// reference model, and directed scenarios for reset, ordering, stalls and timeout.
`ifndef ADDR_WIDTH
 `define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
 `define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
 `define BEN_WIDTH 4
`endif

module tb_ocp_arb2;
   localparam int TO = 8;
   localparam logic [2:0] C_IDLE = 3'b000;
   localparam logic [2:0] C_WR   = 3'b001;
   localparam logic [2:0] C_RD   = 3'b010;
   localparam logic [1:0] R_NULL = 2'b00;
   localparam logic [1:0] R_DVA  = 2'b01;
   localparam logic [1:0] R_ERR  = 2'b11;

   typedef struct {
      logic [2:0]  cmd;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  ben;
   } txn_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [2:0]  m_cmd  [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_data [2];
   logic [3:0]  m_ben  [2];
   logic        acc0, acc1;
   logic [1:0]  resp0, resp1;
   logic [31:0] sdata0, sdata1;
   logic [31:0] o_MAddr, o_MData;
   logic [2:0]  o_MCmd;
   logic [3:0]  o_MByteEn;
   logic        s_acc;
   logic [31:0] s_data;
   logic [1:0]  s_resp;
   logic [1:0]  dbg_state;

   ocp_arb2 #(.TIMEOUT(TO), .CNT_WIDTH(8)) dut (
      .clk(clk), .nrst(nrst),
      .i_M0MAddr(m_addr[0]), .i_M0MCmd(m_cmd[0]), .i_M0MData(m_data[0]), .i_M0MByteEn(m_ben[0]),
      .o_M0SCmdAccept(acc0), .o_M0SData(sdata0), .o_M0SResp(resp0),
      .i_M1MAddr(m_addr[1]), .i_M1MCmd(m_cmd[1]), .i_M1MData(m_data[1]), .i_M1MByteEn(m_ben[1]),
      .o_M1SCmdAccept(acc1), .o_M1SData(sdata1), .o_M1SResp(resp1),
      .o_MAddr(o_MAddr), .o_MCmd(o_MCmd), .o_MData(o_MData), .o_MByteEn(o_MByteEn),
      .i_SCmdAccept(s_acc), .i_SData(s_data), .i_SResp(s_resp),
      .o_dbg_state(dbg_state)
   );

   // ---------------- bench state ----------------
   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   txn_t        mq [2][$];
   logic [31:0] exp_q [2][$];
   bit          m_busy [2];
   bit          m_wait_rd [2];
   bit          m_is_rd [2];
   int          glog [$];
   int          rd_acc_cyc [2];
   int          err_cyc [2];
   bit          rand_en, abort_en, spur_en;

   int          acc_left, acc_min, acc_max;
   bit          rd_pend;
   int          rd_left, rsp_min, rsp_max;
   logic [31:0] rd_addr;

   // Reference model: the in-flight transaction and the round-robin pointer.
   bit mdl_busy, mdl_acc_done;
   int mdl_owner, mdl_last, mdl_wcnt;

   logic        sn_acc [2];
   logic [1:0]  sn_resp [2];
   logic [31:0] sn_sdata [2];
   logic [2:0]  sn_mcmd;
   logic [31:0] sn_maddr, sn_mdata;
   logic        sn_sacc;

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      return a ^ 32'h1234_5678;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   // ---------------- per-cycle comparison + model advance ----------------
   task automatic compare_cycle();
      logic [2:0]  e_cmd;
      logic [31:0] e_addr, e_data;
      logic [3:0]  e_ben;
      logic        e_acc [2];
      logic [1:0]  e_resp [2];
      logic [31:0] e_sd [2];
      bit in_resp, to_now, r0, r1;
      int o;
      cyc++;
      o       = mdl_owner;
      in_resp = mdl_busy && mdl_acc_done;
      to_now  = 1'b0;
`ifdef ARB_TIMEOUT_EN
      to_now  = in_resp && (mdl_wcnt == TO) && (s_resp == R_NULL);
`endif
      e_cmd = C_IDLE; e_addr = '0; e_data = '0; e_ben = '0;
      for (int i = 0; i < 2; i++) begin
         e_acc[i] = 1'b0; e_resp[i] = R_NULL; e_sd[i] = '0;
      end
      if (mdl_busy && !mdl_acc_done) begin
         e_cmd = m_cmd[o]; e_addr = m_addr[o]; e_data = m_data[o]; e_ben = m_ben[o];
         e_acc[o] = s_acc;
      end
      if (in_resp) begin
         e_resp[o] = to_now ? R_ERR : s_resp;
         e_sd[o]   = to_now ? 32'h0 : s_data;
      end
      check("mcmd", 64'(o_MCmd), 64'(e_cmd));
      if (!in_resp) begin
         check("maddr", 64'(o_MAddr), 64'(e_addr));
         check("mdata", 64'(o_MData), 64'(e_data));
         check("mben",  64'(o_MByteEn), 64'(e_ben));
      end
      check("acc0",   64'(acc0),   64'(e_acc[0]));
      check("acc1",   64'(acc1),   64'(e_acc[1]));
      check("resp0",  64'(resp0),  64'(e_resp[0]));
      check("resp1",  64'(resp1),  64'(e_resp[1]));
      check("sdata0", 64'(sdata0), 64'(e_sd[0]));
      check("sdata1", 64'(sdata1), 64'(e_sd[1]));

      sn_acc[0] = acc0;  sn_acc[1] = acc1;
      sn_resp[0] = resp0; sn_resp[1] = resp1;
      sn_sdata[0] = sdata0; sn_sdata[1] = sdata1;
      sn_mcmd = o_MCmd; sn_maddr = o_MAddr; sn_mdata = o_MData; sn_sacc = s_acc;

      if (nrst) begin
         r0 = (m_cmd[0] != C_IDLE);
         r1 = (m_cmd[1] != C_IDLE);
         if (!mdl_busy) begin
            if (r0 || r1) begin
               mdl_busy = 1'b1; mdl_acc_done = 1'b0;
               mdl_owner = (r0 && r1) ? 1 - mdl_last : (r1 ? 1 : 0);
            end
         end else if (!mdl_acc_done) begin
            if (m_cmd[o] == C_IDLE) mdl_busy = 1'b0;
            else if (s_acc) begin
               if (m_cmd[o] == C_RD) begin mdl_acc_done = 1'b1; mdl_wcnt = 0; end
               else begin mdl_busy = 1'b0; mdl_last = o; end
            end
         end else if (s_resp != R_NULL || to_now) begin
            mdl_busy = 1'b0; mdl_last = o;
         end else begin
            mdl_wcnt++;
         end
      end
   endtask

   // ---------------- driver tasks (masters + slave) ----------------
   task automatic agents_update();
      txn_t t;
      bit   aborted;
      logic [31:0] e;
      if (!nrst) return;
      // slave bookkeeping from the edge just taken
      if (rd_pend) begin
         if (rd_left == 0) rd_pend = 1'b0;
         else rd_left--;
      end
      if (sn_sacc && sn_mcmd == C_RD) begin
         rd_pend = 1'b1; rd_left = $urandom_range(rsp_min, rsp_max); rd_addr = sn_maddr;
      end
      if (sn_sacc || sn_mcmd == C_IDLE) acc_left = -1;
      for (int m = 0; m < 2; m++) begin
         aborted = 1'b0;
         if (m_busy[m] && sn_acc[m]) begin
            glog.push_back(m);
            if (m_is_rd[m]) begin
               m_wait_rd[m] = 1'b1;
               exp_q[m].push_back(rd_fn(m_addr[m]));
               rd_acc_cyc[m] = cyc;
            end else begin
               check("wr_addr", 64'(sn_maddr), 64'(m_addr[m]));
               check("wr_data", 64'(sn_mdata), 64'(m_data[m]));
            end
            m_busy[m] = 1'b0; m_cmd[m] = C_IDLE;
         end else if (m_wait_rd[m] && sn_resp[m] != R_NULL) begin
            e = (exp_q[m].size() > 0) ? exp_q[m].pop_front() : 32'hDEAD_BEEF;
            if (sn_resp[m] == R_DVA) check("rdata", 64'(sn_sdata[m]), 64'(e));
            else begin
               check("errdata", 64'(sn_sdata[m]), 64'h0);
               err_cyc[m] = cyc;
            end
            m_wait_rd[m] = 1'b0;
         end else if (m_busy[m] && abort_en && $urandom_range(0, 47) == 0) begin
            m_busy[m] = 1'b0; m_cmd[m] = C_IDLE; aborted = 1'b1;
         end
         if (rand_en && mq[m].size() == 0 && $urandom_range(0, 3) == 0) begin
            t.cmd  = ($urandom_range(0, 1) == 1) ? C_RD : C_WR;
            t.addr = $urandom; t.data = $urandom; t.ben = 4'($urandom_range(1, 15));
            mq[m].push_back(t);
         end
         if (!aborted && !m_busy[m] && !m_wait_rd[m] && mq[m].size() > 0) begin
            t = mq[m].pop_front();
            m_cmd[m] = t.cmd; m_addr[m] = t.addr; m_data[m] = t.data; m_ben[m] = t.ben;
            m_busy[m] = 1'b1; m_is_rd[m] = (t.cmd == C_RD);
         end else if (!m_busy[m]) begin
            m_addr[m] = $urandom; m_data[m] = $urandom;
         end
      end
   endtask

   task automatic drive_slave();
      if (!nrst) begin
         s_acc = 1'b0; s_resp = R_NULL; s_data = '0;
         return;
      end
      if (o_MCmd != C_IDLE && !rd_pend) begin
         if (acc_left < 0) acc_left = $urandom_range(acc_min, acc_max);
         s_acc = (acc_left == 0);
         if (acc_left > 0) acc_left--;
      end else begin
         s_acc = (spur_en && o_MCmd == C_IDLE) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (rd_pend) begin
         s_resp = (rd_left == 0) ? R_DVA : R_NULL;
         s_data = (rd_left == 0) ? rd_fn(rd_addr) : $urandom;
      end else begin
         s_resp = (spur_en && $urandom_range(0, 5) == 0) ?
                  (($urandom_range(0, 1) == 1) ? R_ERR : R_DVA) : R_NULL;
         s_data = $urandom;
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare_cycle();
      @(posedge clk);
      #1;
      agents_update();
      #1;
      drive_slave();
   endtask

   task automatic clear_bench();
      for (int m = 0; m < 2; m++) begin
         m_cmd[m] = C_IDLE; m_addr[m] = '0; m_data[m] = '0; m_ben[m] = '0;
         m_busy[m] = 1'b0; m_wait_rd[m] = 1'b0; m_is_rd[m] = 1'b0;
         mq[m].delete(); exp_q[m].delete();
      end
      s_acc = 1'b0; s_resp = R_NULL; s_data = '0;
      acc_left = -1; rd_pend = 1'b0; rd_left = 0; rd_addr = '0;
      mdl_busy = 1'b0; mdl_acc_done = 1'b0; mdl_owner = 0; mdl_last = 1; mdl_wcnt = 0;
   endtask

   function automatic bit all_idle();
      return mq[0].size() == 0 && mq[1].size() == 0 && !m_busy[0] && !m_busy[1] &&
             !m_wait_rd[0] && !m_wait_rd[1] && !mdl_busy && !rd_pend;
   endfunction

   task automatic run_until_idle(input int budget);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!all_idle() && n < budget);
      if (!all_idle()) check("drain_budget", 64'(n), 64'(budget + 1));
   endtask

   function automatic txn_t mk(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
      txn_t t;
      t.cmd = c; t.addr = a; t.data = d; t.ben = 4'hF;
      return t;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1);
   end

   // ---------------- main sequence + scoreboard report ----------------
   initial begin
      int n;
      nrst = 1'b0;
      rand_en = 1'b0; abort_en = 1'b0; spur_en = 1'b0;
      acc_min = 0; acc_max = 0; rsp_min = 0; rsp_max = 0;
      rd_acc_cyc[0] = 0; rd_acc_cyc[1] = 0; err_cyc[0] = 0; err_cyc[1] = 0;
      clear_bench();
      repeat (3) step();
      check("reset_state", 64'(dbg_state), 64'h0);
      nrst = 1'b1;

      // single M0 write, immediate accept
      glog.delete();
      mq[0].push_back(mk(C_WR, 32'h0, 32'h000F_FFF0));
      run_until_idle(20);
      check("t1_grants", 64'(glog.size()), 64'd1);
      if (glog.size() > 0) check("t1_owner", 64'(glog[0]), 64'd0);

      // M1 read, response after 3 cycles
      glog.delete();
      rsp_min = 3; rsp_max = 3;
      mq[1].push_back(mk(C_RD, 32'h0, 32'h0));
      run_until_idle(20);
      check("t2_owner", 64'(glog.size() == 1 && glog[0] == 1), 64'd1);

      // simultaneous reads, four rounds: strict alternation starting at M0
      glog.delete();
      rsp_min = 0; rsp_max = 0;
      for (int i = 0; i < 4; i++) begin
         mq[0].push_back(mk(C_RD, 32'h100 + 32'(i), 32'h0));
         mq[1].push_back(mk(C_RD, 32'h200 + 32'(i), 32'h0));
      end
      run_until_idle(100);
      check("t3_count", 64'(glog.size()), 64'd8);
      for (int i = 0; i < 8 && i < glog.size(); i++)
         check("t3_order", 64'(glog[i]), 64'(i % 2));

      // slave stalls accept for 5 cycles; other master waits then is served
      glog.delete();
      acc_min = 5; acc_max = 5;
      mq[0].push_back(mk(C_WR, 32'hA0, 32'hCAFE_0000));
      mq[1].push_back(mk(C_WR, 32'hB0, 32'hCAFE_0001));
      run_until_idle(60);
      check("t4_order", 64'(glog.size() == 2 && glog[0] == 0 && glog[1] == 1), 64'd1);
      acc_min = 0; acc_max = 0;

      // reset in the middle of an M1 read response phase
      rsp_min = 10; rsp_max = 10;
      mq[1].push_back(mk(C_RD, 32'h40, 32'h0));
      n = 0;
      while (!(mdl_busy && mdl_acc_done) && n < 30) begin step(); n++; end
      check("t5_reached_resp", 64'(mdl_busy && mdl_acc_done), 64'd1);
      step(); step();
      nrst = 1'b0;
      #1;
      check("t5_rst_mcmd",  64'(o_MCmd), 64'h0);
      check("t5_rst_resp1", 64'(resp1), 64'h0);
      check("t5_rst_state", 64'(dbg_state), 64'h0);
      clear_bench();
      repeat (2) step();
      nrst = 1'b1;
      glog.delete();
      rsp_min = 1; rsp_max = 1;
      mq[1].push_back(mk(C_RD, 32'h44, 32'h0));
      run_until_idle(20);
      check("t5_regrant", 64'(glog.size() == 1 && glog[0] == 1), 64'd1);

`ifdef ARB_TIMEOUT_EN
      // slave accepts an M0 read but answers too late: ERR after TO cycles in RESP
      glog.delete();
      err_cyc[0] = 0;
      rsp_min = TO + 2; rsp_max = TO + 2;
      mq[0].push_back(mk(C_RD, 32'h80, 32'h0));
      step();
      mq[1].push_back(mk(C_WR, 32'h84, 32'h5555_AAAA));
      run_until_idle(80);
      check("t6_err_delay", 64'(err_cyc[0] - (rd_acc_cyc[0] + 1)), 64'(TO));
      check("t6_order", 64'(glog.size() == 2 && glog[0] == 0 && glog[1] == 1), 64'd1);
      rsp_max = TO + 3;
`else
      rsp_max = 4;
`endif

      // randomised traffic
      rsp_min = 0; acc_min = 0; acc_max = 3;
      rand_en = 1'b1; abort_en = 1'b1; spur_en = 1'b1;
      repeat (1500) step();
      rand_en = 1'b0; abort_en = 1'b0; spur_en = 1'b0;
      run_until_idle(400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ocp_arb2.md
Name: ocp_arb2

Overview:
- Two-master to one-slave OCP arbiter. Shares a single OCP slave (e.g. sim_control, memory) between two masters (e.g. instruction fetch = M0, data = M1).
- Round-robin grant, one transaction in flight at a time.
- Reads complete on a slave response; writes are posted and complete on command accept.
- Sits between the core bus ports and the slave in SoC top and testbenches.

Parameters:
TIMEOUT, 255, response watchdog limit in cycles (used only with ARB_TIMEOUT_EN)
CNT_WIDTH, 8, watchdog counter width; must satisfy 2^CNT_WIDTH > TIMEOUT

Ports:
clk  in  1  clock, all state on posedge
nrst  in  1  asynchronous active-low reset
i_M0MAddr / i_M1MAddr  in  `ADDR_WIDTH  master address
i_M0MCmd / i_M1MCmd  in  3  master command (`OCP_CMD_IDLE/READ/WRITE)
i_M0MData / i_M1MData  in  `DATA_WIDTH  master write data
i_M0MByteEn / i_M1MByteEn  in  `BEN_WIDTH  master byte enables
o_M0SCmdAccept / o_M1SCmdAccept  out  1  command accepted, to master
o_M0SData / o_M1SData  out  `DATA_WIDTH  read data, to master
o_M0SResp / o_M1SResp  out  2  response, to master
o_MAddr  out  `ADDR_WIDTH  address, to slave
o_MCmd  out  3  command, to slave
o_MData  out  `DATA_WIDTH  write data, to slave
o_MByteEn  out  `BEN_WIDTH  byte enables, to slave
i_SCmdAccept  in  1  slave accept
i_SData  in  `DATA_WIDTH  slave read data
i_SResp  in  2  slave response (NULL 2'b00, DVA 2'b01, ERR 2'b11)

Behaviour:
- Reset (nrst=0, asynchronous): state=IDLE, grant=none, last-granted pointer=M1 (so M0 wins first), watchdog=0.
- Outputs while in reset and whenever not owned: o_MCmd=IDLE; o_MAddr/o_MData/o_MByteEn=0; all o_MxSCmdAccept=0; o_MxSResp=NULL; o_MxSData=0.
- Master rule: a master holds MCmd/MAddr/MData/MByteEn stable until its SCmdAccept is sampled high.
- State IDLE:
  - If any MxMCmd!=IDLE at posedge: register the grant and go to CMD.
  - Round-robin: if both request, grant the master other than the last granted; if one requests, grant it.
  - Arbitration latency is 1 cycle; the slave sees the command in the cycle after the request.
- State CMD:
  - Slave outputs are a combinational mux of the owner's live inputs.
  - o_MxSCmdAccept of the owner = i_SCmdAccept; the non-owner always sees 0.
  - On i_SCmdAccept=1 with WRITE: go to IDLE and update the pointer to the owner.
  - On i_SCmdAccept=1 with READ: go to RESP.
  - If the owner's MCmd drops to IDLE before accept: abort to IDLE, pointer unchanged, nothing forwarded.
- State RESP:
  - o_MCmd=IDLE.
  - Owner's o_MxSResp/o_MxSData = i_SResp/i_SData combinationally.
  - On i_SResp!=NULL: go to IDLE and update the pointer to the owner.
- Back-to-back:
  - From IDLE entry the next grant is taken at the following posedge; minimum 2 cycles per write, 3 per read at zero slave wait.
  - Requests arriving during CMD/RESP wait; they are never dropped or reordered.
- A slave response in IDLE or CMD is ignored; it is not routed to either master.
- Mid-transaction reset: immediate return to IDLE, all outputs at reset values; the interrupted transaction is lost.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A watchdog counts cycles spent in RESP, cleared on RESP entry.
  - On reaching TIMEOUT with i_SResp still NULL, the owner gets o_MxSResp=ERR (2'b11) and o_MxSData=0 for exactly one cycle, then the FSM returns to IDLE and updates the pointer.
  - A slave response arriving in the same cycle as the timeout takes priority (DVA wins).
- Undefined: no counter is present; RESP waits indefinitely.

Test Plan:
1. Reset then single M0 write 0x0 data 0x000F_FFF0, slave accepts immediately -> o_MCmd=WRITE one cycle after request with o_MData=0x000F_FFF0; o_M0SCmdAccept=1; o_M1* stay idle; FSM back to IDLE.
2. M1 read 0x0, slave accepts and returns DVA data 0x1234_5678 after 3 cycles -> o_M1SResp=DVA with o_M1SData=0x1234_5678 in that cycle; o_M0SResp=NULL throughout.
3. M0 and M1 request reads in the same cycle, repeated 4 times -> grant order M0,M1,M0,M1; no overlap of o_MCmd between owners.
4. Slave holds i_SCmdAccept=0 for 5 cycles -> o_MCmd/o_MAddr stay stable on the owner's values; the other master's request stays pending and is served after completion.
5. nrst pulsed low during RESP of an M1 read -> all outputs reset immediately; after release, a new M1 request is granted normally.
6. With ARB_TIMEOUT_EN and TIMEOUT=8, slave accepts a read but never responds -> o_M0SResp=ERR exactly 8 cycles after RESP entry; the next queued M1 request is then granted.
